// File: rtl/mem_ctrl_multi.sv
// mem_ctrl_multi: byte-serial memory controller for NUM_CH requesters
// sharing the 8-bit RAM/IO bus. Round-robin arbitration, byte/half/word
// transfers, flush of in-flight reads and a stall for writes to a full IO
// buffer.
//
// Ports:
//   clk_in, rst_in       clock, synchronous active-high reset
//   rdy_in               global enable; low freezes all state
//   flush_in             aborts an in-flight read, blocks a grant in IDLE
//   io_buffer_full       stalls writes whose addr[17:16] == IO_HI
//   req_*                per-channel request (valid held until req_ack)
//   req_ack, resp_valid  per-channel one-cycle pulses
//   resp_data            load data, zero-extended, valid with resp_valid
//   mem_din/mem_dout/mem_a/mem_wr  RAM/IO bus (mem_din one cycle after mem_a)
module mem_ctrl_multi #(
    parameter int         NUM_CH = 2,
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = 2'b11
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           rdy_in,
    input  logic                           flush_in,
    input  logic                           io_buffer_full,
    input  logic [NUM_CH-1:0]              req_valid,
    input  logic [NUM_CH-1:0]              req_write,
    input  logic [NUM_CH-1:0][1:0]         req_size,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr,
    input  logic [NUM_CH-1:0][31:0]        req_wdata,
    output logic [NUM_CH-1:0]              req_ack,
    output logic [NUM_CH-1:0]              resp_valid,
    output logic [31:0]                    resp_data,
    input  logic [7:0]                     mem_din,
    output logic [7:0]                     mem_dout,
    output logic [ADDR_W-1:0]              mem_a,
    output logic                           mem_wr
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, XFER, TAIL} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic              write;
        logic [2:0]        nbytes;
        logic [PTR_W-1:0]  ch;
    } txn_t;

    state_t             state, state_d;
    txn_t               txn, txn_d;
    logic [2:0]         i, i_d;          // addresses issued so far
    logic [PTR_W-1:0]   rr_ptr, rr_d;
    logic [ADDR_W-1:0]  mem_a_d;
    logic [7:0]         mem_dout_d;
    logic               mem_wr_d;
    logic [NUM_CH-1:0]  ack_d, rv_d;
    logic [31:0]        rdata_d;

    logic               found;
    logic [PTR_W-1:0]   gnt, cand;
    logic [1:0]         cap_idx, tail_idx;
    logic               io_stall;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            cand = PTR_W'((int'(rr_ptr) + off) % NUM_CH);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                gnt   = cand;
            end
        end
    end

    // mem_din at a clock edge is the byte for the address shown in the
    // previous cycle, i.e. two issues behind the counter.
    assign cap_idx  = 2'(i - 3'd2);
    assign tail_idx = 2'(txn.nbytes - 3'd1);
    assign io_stall = (txn.addr[17:16] == IO_HI) && io_buffer_full;

    always_comb begin
        state_d    = state;
        txn_d      = txn;
        i_d        = i;
        rr_d       = rr_ptr;
        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        mem_wr_d   = 1'b0;
        ack_d      = '0;
        rv_d       = '0;
        rdata_d    = resp_data;
        case (state)
            IDLE: begin
                if (found && !flush_in) begin
                    txn_d.addr  = req_addr[gnt];
                    txn_d.wdata = req_wdata[gnt];
                    txn_d.write = req_write[gnt];
                    txn_d.ch    = gnt;
                    case (req_size[gnt])
                        2'd0:    txn_d.nbytes = 3'd1;
                        2'd1:    txn_d.nbytes = 3'd2;
                        default: txn_d.nbytes = 3'd4;
                    endcase
                    ack_d[gnt] = 1'b1;
                    rr_d       = (gnt == PTR_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
                    i_d        = '0;
                    if (!req_write[gnt]) rdata_d = '0;   // upper bytes read 0
                    state_d    = XFER;
                end
            end
            XFER: begin
                if (txn.write) begin
                    // Writes ignore flush and always run to completion.
                    if (i == txn.nbytes) begin
                        rv_d[txn.ch] = 1'b1;
                        state_d      = IDLE;
                    end else if (!io_stall) begin
                        mem_a_d    = txn.addr + ADDR_W'(i);
                        mem_wr_d   = 1'b1;
                        mem_dout_d = txn.wdata[{i[1:0], 3'b000} +: 8];
                        i_d        = i + 3'd1;
                    end
                end else if (flush_in) begin
                    state_d = IDLE;
                end else begin
                    if (i >= 3'd2) rdata_d[{cap_idx, 3'b000} +: 8] = mem_din;
                    if (i == txn.nbytes) begin
                        state_d = TAIL;
                    end else begin
                        mem_a_d = txn.addr + ADDR_W'(i);
                        i_d     = i + 3'd1;
                    end
                end
            end
            TAIL: begin
                state_d = IDLE;
                if (!flush_in) begin
                    rdata_d[{tail_idx, 3'b000} +: 8] = mem_din;
                    rv_d[txn.ch] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= IDLE;
            txn        <= '0;
            i          <= '0;
            rr_ptr     <= '0;
            mem_a      <= '0;
            mem_dout   <= '0;
            mem_wr     <= 1'b0;
            req_ack    <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else if (!rdy_in) begin
            // Frozen, but strobes drop so a paused cycle never repeats a
            // write or a handshake pulse.
            mem_wr     <= 1'b0;
            req_ack    <= '0;
            resp_valid <= '0;
        end else begin
            state      <= state_d;
            txn        <= txn_d;
            i          <= i_d;
            rr_ptr     <= rr_d;
            mem_a      <= mem_a_d;
            mem_dout   <= mem_dout_d;
            mem_wr     <= mem_wr_d;
            req_ack    <= ack_d;
            resp_valid <= rv_d;
            resp_data  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_multi.sv
module tb_mem_ctrl_multi;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, flush_in, io_buffer_full;
    logic [NUM_CH-1:0]             req_valid, req_write;
    logic [NUM_CH-1:0][1:0]        req_size;
    logic [NUM_CH-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_CH-1:0][31:0]       req_wdata;
    logic [NUM_CH-1:0]             req_ack, resp_valid;
    logic [31:0]                   resp_data;
    logic [7:0]                    mem_din, mem_dout;
    logic [ADDR_W-1:0]             mem_a;
    logic                          mem_wr;

    int total = 0;
    int bad   = 0;

    // RAM model: registered read, write on mem_wr; bench pokes via port.
    logic [7:0]  ram [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_a  = '0;
    logic [7:0]  poke_d  = '0;

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (poke_en)     ram[poke_a] <= poke_d;
        else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
        mem_din <= ram[mem_a[15:0]];
    end

    mem_ctrl_multi #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .IO_HI(2'b11)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .io_buffer_full(io_buffer_full),
        .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .resp_valid(resp_valid), .resp_data(resp_data),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        poke_a = a; poke_d = d; poke_en = 1'b1;
        @(negedge clk_in);
        poke_en = 1'b0;
    endtask

    task automatic set_req(input int ch, input logic wr, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd);
        req_valid[ch] = 1'b1; req_write[ch] = wr; req_size[ch] = sz;
        req_addr[ch] = a; req_wdata[ch] = wd;
    endtask

    // Returns at the negedge of the ack cycle (T) or after a bounded wait.
    task automatic wait_ack(input int ch, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            if (req_ack[ch]) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst_in = 1'b1; rdy_in = 1'b1; flush_in = 1'b0; io_buffer_full = 1'b0;
        req_valid = '0; req_write = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk_in);
        total += 6;
        if (req_ack !== 2'b00)    begin bad++; $display("FAIL reset_ack got %b want 00", req_ack); end
        if (resp_valid !== 2'b00) begin bad++; $display("FAIL reset_rv got %b want 00", resp_valid); end
        if (mem_wr !== 1'b0)      begin bad++; $display("FAIL reset_wr got %b want 0", mem_wr); end
        if (mem_dout !== 8'h00)   begin bad++; $display("FAIL reset_dout got %h want 00", mem_dout); end
        if (mem_a !== 32'h0)      begin bad++; $display("FAIL reset_a got %h want 0", mem_a); end
        if (resp_data !== 32'h0)  begin bad++; $display("FAIL reset_data got %h want 0", resp_data); end
        rst_in = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_word_read;
        bit ok;
        poke(16'h0100, 8'h11); poke(16'h0101, 8'h22);
        poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
        set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
        wait_ack(0, ok);
        req_valid[0] = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL wr_ack got none want ack"); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in);
            if (c <= 4) begin
                total++;
                if (mem_a !== 32'h100 + c - 1 || mem_wr !== 1'b0) begin
                    bad++; $display("FAIL rd_addr c=%0d got %h/%b want %h/0", c, mem_a, mem_wr, 32'h100 + c - 1);
                end
            end
            total++;
            if (resp_valid[0] !== (c == 6)) begin
                bad++; $display("FAIL rd_rv c=%0d got %b want %b", c, resp_valid[0], c == 6);
            end
        end
        total++;
        if (resp_data !== 32'h44332211) begin bad++; $display("FAIL rd_data got %h want 44332211", resp_data); end
    endtask

    task automatic test_half_write;
        bit ok;
        set_req(1, 1'b1, 2'd1, 32'h200, 32'h0000ABCD);
        wait_ack(1, ok);
        req_valid[1] = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL hw_ack got none want ack"); end
        @(negedge clk_in);
        total++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h200, 8'hCD}) begin
            bad++; $display("FAIL hw_b0 got %b %h %h want 1 200 cd", mem_wr, mem_a, mem_dout);
        end
        @(negedge clk_in);
        total++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h201, 8'hAB}) begin
            bad++; $display("FAIL hw_b1 got %b %h %h want 1 201 ab", mem_wr, mem_a, mem_dout);
        end
        @(negedge clk_in);
        total++;
        if (resp_valid !== 2'b10 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL hw_rv got %b wr=%b want 10 wr=0", resp_valid, mem_wr);
        end
        total++;
        if (ram[16'h0201] !== 8'hAB) begin bad++; $display("FAIL hw_ram got %h want ab", ram[16'h0201]); end
    endtask

    task automatic test_round_robin;
        int seq [4];
        int n = 0, r0 = 0, r1 = 0, left = 10;
        bit stopped = 1'b0;
        set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
        set_req(1, 1'b0, 2'd0, 32'h102, 32'h0);
        for (int k = 0; k < 80; k++) begin
            @(negedge clk_in);
            if (req_ack == 2'b01 && n < 4) begin seq[n] = 0; n++; end
            else if (req_ack == 2'b10 && n < 4) begin seq[n] = 1; n++; end
            if (resp_valid[0]) begin
                r0++; total++;
                if (resp_data !== 32'h44332211) begin bad++; $display("FAIL rr_d0 got %h want 44332211", resp_data); end
            end
            if (resp_valid[1]) begin
                r1++; total++;
                if (resp_data !== 32'h00000033) begin bad++; $display("FAIL rr_d1 got %h want 00000033", resp_data); end
            end
            if (n == 4 && !stopped) begin req_valid = '0; stopped = 1'b1; end
            if (stopped) begin left--; if (left == 0) break; end
        end
        req_valid = '0;
        total++;
        if (n != 4) begin bad++; $display("FAIL rr_count got %0d want 4", n); end
        for (int g = 0; g < n; g++) begin
            total++;
            if (seq[g] != g % 2) begin bad++; $display("FAIL rr_seq g=%0d got %0d want %0d", g, seq[g], g % 2); end
        end
        total++;
        if (r0 != 2 || r1 != 2) begin bad++; $display("FAIL rr_resps got %0d/%0d want 2/2", r0, r1); end
    endtask

    task automatic test_io_stall;
        bit ok;
        io_buffer_full = 1'b1;
        set_req(0, 1'b1, 2'd0, 32'h00030000, 32'h0000005A);
        wait_ack(0, ok);
        req_valid[0] = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL io_ack got none want ack"); end
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_in);
            total++;
            if (mem_wr !== 1'b0 || resp_valid !== 2'b00) begin
                bad++; $display("FAIL io_stall c=%0d got wr=%b rv=%b want 0/00", c, mem_wr, resp_valid);
            end
        end
        io_buffer_full = 1'b0;
        @(negedge clk_in);
        total++;
        if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h00030000, 8'h5A}) begin
            bad++; $display("FAIL io_byte got %b %h %h want 1 30000 5a", mem_wr, mem_a, mem_dout);
        end
        @(negedge clk_in);
        total++;
        if (resp_valid !== 2'b01 || mem_wr !== 1'b0) begin
            bad++; $display("FAIL io_rv got %b wr=%b want 01 wr=0", resp_valid, mem_wr);
        end
    endtask

    task automatic test_flush;
        bit ok;
        set_req(0, 1'b0, 2'd2, 32'h100, 32'h0);
        wait_ack(0, ok);
        req_valid[0] = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL fl_ack0 got none want ack"); end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_in);
            total++;
            if (resp_valid[0] !== 1'b0) begin bad++; $display("FAIL fl_norv c=%0d got 1 want 0", c); end
            if (c == 2) flush_in = 1'b1;
            if (c == 3) begin flush_in = 1'b0; set_req(1, 1'b0, 2'd0, 32'h101, 32'h0); end
            if (c == 4) begin
                total++;
                if (req_ack !== 2'b10) begin bad++; $display("FAIL fl_ack1 got %b want 10", req_ack); end
                req_valid[1] = 1'b0;
            end
            if (c == 7) begin
                total++;
                if (resp_valid[1] !== 1'b1 || resp_data !== 32'h00000022) begin
                    bad++; $display("FAIL fl_resp1 got %b %h want 1 00000022", resp_valid[1], resp_data);
                end
            end
        end
    endtask

    task automatic test_rdy_pause;
        bit ok;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        set_req(1, 1'b1, 2'd2, 32'h400, 32'hDEADBEEF);
        wait_ack(1, ok);
        req_valid[1] = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL rp_ack got none want ack"); end
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk_in);
            total++;
            if (c == 2 || c == 3) begin
                if (mem_wr !== 1'b0) begin bad++; $display("FAIL rp_pause c=%0d got wr=1 want 0", c); end
            end else if (c < 7) begin
                int b = (c == 1) ? 0 : c - 3;
                if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h400 + b, exp_b[b]}) begin
                    bad++; $display("FAIL rp_byte c=%0d got %b %h %h want 1 %h %h", c, mem_wr, mem_a, mem_dout, 32'h400 + b, exp_b[b]);
                end
            end else begin
                if (resp_valid !== 2'b10) begin bad++; $display("FAIL rp_rv got %b want 10", resp_valid); end
            end
            if (c == 1) rdy_in = 1'b0;
            if (c == 3) rdy_in = 1'b1;
        end
        total++;
        if ({ram[16'h0403], ram[16'h0402], ram[16'h0401], ram[16'h0400]} !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rp_ram got %h%h%h%h want deadbeef", ram[16'h0403], ram[16'h0402], ram[16'h0401], ram[16'h0400]);
        end
    endtask

    task automatic test_wrap_size3;
        bit ok;
        logic [31:0] exp_a [4];
        exp_a[0] = 32'hFFFFFFFE; exp_a[1] = 32'hFFFFFFFF; exp_a[2] = 32'h0; exp_a[3] = 32'h1;
        poke(16'hFFFE, 8'hA1); poke(16'hFFFF, 8'hA2);
        poke(16'h0000, 8'hA3); poke(16'h0001, 8'hA4);
        set_req(0, 1'b0, 2'd3, 32'hFFFFFFFE, 32'h0);
        wait_ack(0, ok);
        req_valid[0] = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL wp_ack got none want ack"); end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_in);
            if (c <= 4) begin
                total++;
                if (mem_a !== exp_a[c-1]) begin bad++; $display("FAIL wp_addr c=%0d got %h want %h", c, mem_a, exp_a[c-1]); end
            end
        end
        total++;
        if (resp_valid[0] !== 1'b1 || resp_data !== 32'hA4A3A2A1) begin
            bad++; $display("FAIL wp_data got %b %h want 1 a4a3a2a1", resp_valid[0], resp_data);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        set_req(0, 1'b1, 2'd2, 32'h500, 32'h01020304);
        wait_ack(0, ok);
        req_valid[0] = 1'b0;
        total++;
        if (!ok) begin bad++; $display("FAIL rm_ack got none want ack"); end
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        total++;
        if (mem_wr !== 1'b0 || mem_a !== 32'h0) begin
            bad++; $display("FAIL rm_wr got %b %h want 0 0", mem_wr, mem_a);
        end
        rst_in = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            total++;
            if (resp_valid !== 2'b00 || mem_wr !== 1'b0) begin
                bad++; $display("FAIL rm_quiet c=%0d got rv=%b wr=%b want 00/0", c, resp_valid, mem_wr);
            end
        end
        set_req(0, 1'b0, 2'd1, 32'h500, 32'h0);
        wait_ack(0, ok);
        req_valid[0] = 1'b0;
        repeat (4) @(negedge clk_in);
        total++;
        if (!ok || resp_valid[0] !== 1'b1 || resp_data[7:0] !== 8'h04 || resp_data[31:16] !== 16'h0) begin
            bad++; $display("FAIL rm_after got ok=%b rv=%b %h want 1 1 ..04", ok, resp_valid[0], resp_data);
        end
    endtask

    initial begin
        test_reset;
        test_word_read;
        test_half_write;
        test_round_robin;
        test_io_stall;
        test_flush;
        test_rdy_pause;
        test_wrap_size3;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl_multi.md
Name: mem_ctrl_multi

Overview:
- Parametrised byte-serial memory controller serving NUM_CH requesters (channel 0 = icache, 1 = LSB, others spare) over the 8-bit RAM/IO bus.
- Successor to the two-fixed-port controller; adds N channels, round-robin arbitration, byte/half/word sizes, flush of in-flight reads, and an IO-full write stall.
- Sits between the cache/LSB layer and the top-level mem_din/mem_dout/mem_a/mem_wr pins.

Parameters:
- NUM_CH, 2, number of requester channels (1..8).
- ADDR_W, 32, address width on the request side and on mem_a.
- IO_HI, 2'b11, value of addr[17:16] that marks the IO region.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global enable; when low, all state is frozen.
- flush_in  input  1  misprediction clear; aborts an in-flight read.
- io_buffer_full  input  1  UART tx buffer full.
- req_valid  input  NUM_CH  per-channel request; held until ack.
- req_write  input  NUM_CH  1 = store, 0 = load.
- req_size  input  2*NUM_CH  0 = byte, 1 = half, 2 = word; 3 is treated as word.
- req_addr  input  ADDR_W*NUM_CH  byte address.
- req_wdata  input  32*NUM_CH  store data, little-endian.
- req_ack  output  NUM_CH  one-cycle pulse when the request is accepted.
- resp_valid  output  NUM_CH  one-cycle pulse when the request completes.
- resp_data  output  32  load data, zero-extended; valid with resp_valid.
- mem_din  input  8  RAM read byte, valid one cycle after its address.
- mem_dout  output  8  RAM write byte.
- mem_a  output  ADDR_W  RAM/IO address.
- mem_wr  output  1  1 = write.

Behaviour:
- Reset: state IDLE; req_ack, resp_valid, mem_wr, mem_dout and mem_a are 0; resp_data is 0; round-robin pointer is 0.
- rdy_in low: no register changes; outputs hold; mem_wr is forced to 0 for the cycle so no write repeats.
- States:
  - IDLE: among req_valid, grant the lowest index at or after rr_ptr (wrapping). Latch channel, addr, size, wdata, write; pulse req_ack[ch]; set rr_ptr = ch+1 mod NUM_CH. Go to XFER with byte counter i = 0 and nbytes = 1, 2 or 4.
  - XFER, write: each cycle drive mem_a = addr+i, mem_wr = 1, mem_dout = wdata[8i+7:8i], then i++.
    - IO stall: if addr[17:16] == IO_HI and io_buffer_full = 1, drive mem_wr = 0 and hold i.
    - After the last byte, pulse resp_valid[ch] the next cycle and go to IDLE.
  - XFER, read: each cycle drive mem_a = addr+i, mem_wr = 0, then i++.
    - Capture the byte for index i-1 from mem_din into resp_data[8(i-1)+7:8(i-1)].
    - After nbytes addresses, go to TAIL.
  - TAIL: capture the last byte, pulse resp_valid[ch] with resp_data complete, go to IDLE.
- Latency from the ack cycle T:
  - Read of k bytes: addresses in cycles T+1..T+k; resp_valid in cycle T+k+2.
  - Write of k bytes without stall: bytes in cycles T+1..T+k; resp_valid in cycle T+k+1.
- Re-arbitration: a new grant happens only in IDLE, so there is at least one idle cycle between transactions.
- flush_in:
  - If high during XFER-read or TAIL: abandon, no resp_valid, go to IDLE next cycle.
  - If high during a write: ignored; writes always complete.
  - If high in IDLE with a request pending: no grant that cycle.
- Unused upper bytes of resp_data for byte/half loads read 0. Sign extension is the requester's job.
- req_valid deasserted after ack does not affect the in-flight transaction.
- Address arithmetic addr+i wraps at ADDR_W.
- Reset asserted mid-transaction: return to IDLE next edge, no response, mem_wr = 0.

Test Plan:
- Word read, ch0, addr 0x100, RAM bytes 0x11 0x22 0x33 0x44 -> ack at T; mem_a = 0x100..0x103 in T+1..T+4; resp_valid[0] at T+6 with resp_data = 0x44332211.
- Half write, ch1, addr 0x200, wdata 0xABCD -> mem_wr = 1 with (0x200, 0xCD) at T+1 and (0x201, 0xAB) at T+2; resp_valid[1] at T+3.
- ch0 and ch1 both held valid, NUM_CH = 2 -> grants alternate 0,1,0,1; neither channel starves.
- Byte write to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr = 0 for those 3 cycles, byte issued on the first cycle full is low, resp follows next cycle.
- Word read, flush_in pulsed at T+2 -> IDLE at T+3, no resp_valid; a following request is acked at T+3 or later.
- rdy_in low for 2 cycles mid word-write -> mem_wr = 0 during the pause, no byte duplicated or lost, completion delayed exactly 2 cycles.
